ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_rx_fifo_pkg.sv | 23 ++
 rtl/ps2_sync_edge.sv | 22 ++
 rtl/ps2_rx_fifo.sv | 125 ++++++++++++
 tb/tb_ps2_rx_fifo.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ps2_rx_fifo_pkg.sv
// Shared constants and frame layout for the PS/2 receive FIFO.
package ps2_rx_fifo_pkg;

  localparam int unsigned PS2_FRAME_BITS         = 11;
  localparam logic [7:0]  PS2_BREAK_CODE         = 8'hF0;
  localparam int unsigned DEFAULT_FIFO_DEPTH     = 8;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50000;
  localparam int unsigned BIT_CNT_W              = 4;

  // Frame as it sits in the shift register once all 11 bits are in (bit0 = start).
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
    logic       start;
  } ps2_frame_t;

  // Start low, stop high, odd parity over data plus parity bit.
  function automatic logic frame_ok(input ps2_frame_t f);
    return (!f.start) && f.stop && (^{f.parity, f.data});
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a one-cycle falling-edge pulse.
module ps2_sync_edge (
  input  logic clk,
  input  logic clrn,
  input  logic din,
  output logic fall
);

  logic [2:0] sync_q;

  // Synchronizer stages (0,1) and the previous-value stage (2); idle level is high.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sync_q <= 3'b111;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], din};
      fall   <= sync_q[2] & ~sync_q[1];
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: deserializes 11-bit frames and queues valid scan codes.
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic                          ps2_fall;
  logic [1:0]                    data_sync_q;
  logic [PS2_FRAME_BITS-1:0]     frame_q;
  logic [BIT_CNT_W-1:0]          bit_cnt_q;
  logic                          frame_done_q;
  logic [TW-1:0]                 tmo_cnt_q;
  logic                          next_q;
  logic [AW-1:0]                 wr_ptr_q;
  logic [AW-1:0]                 rd_ptr_q;
  logic [CW-1:0]                 count_q;
  logic [7:0]                    mem [FIFO_DEPTH];

  ps2_frame_t                    frame_view_c;
  logic                          frame_valid_c;
  logic                          push_c;
  logic                          pop_c;
  logic [CW-1:0]                 count_nxt_c;

  ps2_sync_edge u_clk_sync (
    .clk  (clk),
    .clrn (clrn),
    .din  (ps2_clk),
    .fall (ps2_fall)
  );

  // Plain two-flop synchronizer for the data line.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) data_sync_q <= 2'b11;
    else       data_sync_q <= {data_sync_q[0], ps2_data};
  end

  // Bit shifter, bit counter and stalled-frame timeout.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      frame_q      <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (ps2_fall) begin
        frame_q   <= {data_sync_q[1], frame_q[PS2_FRAME_BITS-1:1]};
        tmo_cnt_q <= '0;
        if (bit_cnt_q == BIT_CNT_W'(PS2_FRAME_BITS - 1)) begin
          bit_cnt_q    <= '0;
          frame_done_q <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
        end
      end else if (bit_cnt_q != '0) begin
        if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt_q <= '0;
          frame_q   <= '0;
          tmo_cnt_q <= '0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + TW'(1);
        end
      end else begin
        tmo_cnt_q <= '0;
      end
    end
  end

  // Push/pop qualification and next occupancy.
  always_comb begin
    frame_view_c  = ps2_frame_t'(frame_q);
    frame_valid_c = frame_done_q && frame_ok(frame_view_c);
    push_c        = frame_valid_c && (count_q != CW'(FIFO_DEPTH));
    pop_c         = next_q && !nextdata_n && (count_q != '0);
    count_nxt_c   = count_q;
    if (push_c && !pop_c)      count_nxt_c = count_q + CW'(1);
    else if (!push_c && pop_c) count_nxt_c = count_q - CW'(1);
  end

  // FIFO pointers, occupancy, status flags and the pop edge register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ready     <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      next_q    <= 1'b1;
    end else begin
      next_q  <= nextdata_n;
      count_q <= count_nxt_c;
      ready   <= (count_nxt_c != '0);
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (frame_valid_c && !push_c) overflow <= 1'b1;
      if (frame_done_q && !frame_ok(frame_view_c)) frame_err <= 1'b1;
    end
  end

  // Scan-code storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= frame_view_c.data;
  end

  assign data = mem[rd_ptr_q];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames, pops, overflow, errors, timeout, reset.
module tb_ps2_rx_fifo;
  import ps2_rx_fifo_pkg::*;

  localparam int HALF = 20;
  localparam int TMO  = 300;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_rx_fifo #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of the frame for byte d (optionally with parity flipped).
  task automatic send_bits(input logic [7:0] d, input logic bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ bad, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad);
    send_bits(d, bad, 11);
  endtask

  task automatic pop;
    nextdata_n = 1'b0;
    wait_cyc(3);
    nextdata_n = 1'b1;
    wait_cyc(3);
  endtask

  task automatic test_reset;
    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
    wait_cyc(3);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    clrn = 1'b1;
    wait_cyc(3);
  endtask

  task automatic test_single;
    send_frame(8'h1C, 1'b0);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", ready); end
    n_checks++; if (data !== 8'h1C) begin n_fail++; $display("FAIL single_data: got %h expected 1c", data); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL single_frame_err: got %b expected 0", frame_err); end
    pop();
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL single_pop_ready: got %b expected 0", ready); end
  endtask

  task automatic test_hold_pop;
    send_frame(PS2_BREAK_CODE, 1'b0);
    send_frame(8'h1C, 1'b0);
    n_checks++; if (data !== 8'hF0) begin n_fail++; $display("FAIL hold_head: got %h expected f0", data); end
    nextdata_n = 1'b0;
    wait_cyc(1000);
    n_checks++; if (data !== 8'h1C) begin n_fail++; $display("FAIL hold_data: got %h expected 1c", data); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready: got %b expected 1", ready); end
    nextdata_n = 1'b1;
    wait_cyc(3);
    pop();
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL hold_drain: got %b expected 0", ready); end
  endtask

  task automatic test_timeout;
    send_bits(8'h55, 1'b0, 5);
    wait_cyc(TMO + 10);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL tmo_ready: got %b expected 0", ready); end
    send_frame(8'h29, 1'b0);
    n_checks++; if (data !== 8'h29) begin n_fail++; $display("FAIL tmo_data: got %h expected 29", data); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL tmo_frame_err: got %b expected 0", frame_err); end
    pop();
  endtask

  task automatic test_overflow;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b expected 0", overflow); end
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready[%0d]: got %b expected 1", i, ready); end
      n_checks++; if (data !== 8'(i)) begin n_fail++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, data, 8'(i)); end
      pop();
    end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b expected 0", ready); end
  endtask

  task automatic test_parity;
    send_frame(8'h58, 1'b1);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL par_frame_err: got %b expected 1", frame_err); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL par_ready: got %b expected 0", ready); end
    send_frame(8'h12, 1'b0);
    n_checks++; if (data !== 8'h12) begin n_fail++; $display("FAIL par_next_data: got %h expected 12", data); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL par_next_ready: got %b expected 1", ready); end
    pop();
  endtask

  task automatic test_reset_mid;
    send_frame(8'hA1, 1'b0);
    send_frame(8'hA2, 1'b0);
    send_frame(8'hA3, 1'b0);
    send_bits(8'h6B, 1'b0, 7);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL mid_pre_overflow: got %b expected 1", overflow); end
    clrn = 1'b0;
    wait_cyc(2);
    clrn = 1'b1;
    wait_cyc(2);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b expected 0", ready); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %b expected 0", overflow); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL mid_frame_err: got %b expected 0", frame_err); end
    // Remaining four bits of the abandoned frame must not produce an entry.
    for (int i = 7; i < 11; i++) ps2_bit((i == 10) ? 1'b1 : 1'b0);
    wait_cyc(TMO + 10);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_no_entry: got %b expected 0", ready); end
    send_frame(8'h33, 1'b0);
    n_checks++; if (data !== 8'h33) begin n_fail++; $display("FAIL mid_after_data: got %h expected 33", data); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_after_ready: got %b expected 1", ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold_pop();
    test_timeout();
    test_overflow();
    test_parity();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
